// File: rtl/referee_router.sv
// referee_router: pops words from one input FIFO, decodes a destination
// field from each word and pushes the word into one of N_CH output FIFOs.
// Words whose destination is >= N_CH are discarded and flagged on drop.
// Optional feature macro: REFEREE_STALL_CNT_EN adds per-channel 8-bit
// saturating stall counters on the stall_cnt output.

module referee_router #(
   parameter int DATA_W  = 12,
   parameter int N_CH    = 4,
   parameter int SEL_LSB = 10,
   parameter int SEL_W   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              empty,
   input  logic [DATA_W-1:0] data_in,
   input  logic [N_CH-1:0]   almost_full,
   output logic              pop,
   output logic [N_CH-1:0]   push,
   output logic [DATA_W-1:0] data_out,
   output logic              drop
`ifdef REFEREE_STALL_CNT_EN
   ,
   output logic [N_CH*8-1:0] stall_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_DATA,
      HOLD
   } state_t;

   state_t              state_q;
   logic [DATA_W-1:0]   hold_q;
   logic [SEL_W-1:0]    dest_q;
   logic [N_CH-1:0]     push_q;
   logic [DATA_W-1:0]   dataOut_q;
   logic                drop_q;

   logic [N_CH-1:0]     destHit;
   logic                destValid;
   logic                afSel;
   logic                stalled;

   // Decode the held destination into a one-hot channel select; no hit means out of range
   always_comb begin
      destHit = '0;
      for (int i = 0; i < N_CH; i++) begin
         destHit[i] = (dest_q == SEL_W'(i));
      end
      destValid = |destHit;
      afSel     = |(destHit & almost_full);
      stalled   = (state_q == HOLD) && destValid && afSel;
   end

   // Read strobe: idle pops when data is waiting, HOLD pops in the same cycle it releases its word
   always_comb begin
      pop = 1'b0;
      if (reset) begin
         case (state_q)
            IDLE:    pop = !empty;
            HOLD:    pop = !empty && !stalled;
            default: pop = 1'b0;
         endcase
      end
   end

   // Main FSM with registered push/drop/data_out
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         dest_q    <= '0;
         push_q    <= '0;
         dataOut_q <= '0;
         drop_q    <= 1'b0;
      end else begin
         push_q <= '0;
         drop_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop) state_q <= WAIT_DATA;
            end
            WAIT_DATA: begin
               hold_q  <= data_in;
               dest_q  <= data_in[SEL_LSB +: SEL_W];
               state_q <= HOLD;
            end
            HOLD: begin
               if (!destValid) begin
                  drop_q  <= 1'b1;
                  state_q <= pop ? WAIT_DATA : IDLE;
               end else if (!afSel) begin
                  push_q    <= destHit;
                  dataOut_q <= hold_q;
                  state_q   <= pop ? WAIT_DATA : IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign push     = push_q;
   assign data_out = dataOut_q;
   assign drop     = drop_q;

`ifdef REFEREE_STALL_CNT_EN
   logic [N_CH-1:0][7:0] stallCnt_q;

   // Per-channel saturating count of cycles stalled in HOLD, cleared when that channel dispatches
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stallCnt_q <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if ((state_q == HOLD) && destHit[i]) begin
               if (afSel) begin
                  if (stallCnt_q[i] != 8'hFF) stallCnt_q[i] <= stallCnt_q[i] + 8'd1;
               end else begin
                  stallCnt_q[i] <= 8'd0;
               end
            end
         end
      end
   end

   assign stall_cnt = stallCnt_q;
`endif

endmodule
